// File: rtl/parity_stream_counter.sv
// parity_stream_counter: counts valid odd/even words (by d_in[0]) with
// wrap or saturate overflow, sticky overflow flags and registered majority.
module parity_stream_counter #(
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned CNT_W    = 4,
   parameter bit          SAT_MODE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] d_in,
   output logic [CNT_W-1:0]  count_odd,
   output logic [CNT_W-1:0]  count_even,
   output logic [CNT_W:0]    count_total,
   output logic              odd_ovf,
   output logic              even_ovf,
   output logic              odd_major,
   output logic              even_major
);

   localparam int unsigned TOT_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Only the LSB classifies a word; the upper bits are intentionally ignored.
   logic unused_d_in;
   assign unused_d_in = ^d_in;

   logic             inc_odd;
   logic             inc_even;
   logic             odd_at_max;
   logic             even_at_max;
   logic [CNT_W-1:0] odd_nxt;
   logic [CNT_W-1:0] even_nxt;
   logic             odd_ovf_nxt;
   logic             even_ovf_nxt;

   // Increment requests; clr dominates and in_valid gates d_in so X data is harmless.
   always_comb begin
      inc_odd     = 1'b0;
      inc_even    = 1'b0;
      odd_at_max  = (count_odd == CNT_MAX);
      even_at_max = (count_even == CNT_MAX);
      if (!clr && in_valid) begin
         inc_odd  = d_in[0];
         inc_even = ~d_in[0];
      end
   end

   // Next-count and sticky-flag logic with wrap/saturate policy at max.
   always_comb begin
      odd_nxt      = count_odd;
      even_nxt     = count_even;
      odd_ovf_nxt  = odd_ovf;
      even_ovf_nxt = even_ovf;
      if (clr) begin
         odd_nxt      = '0;
         even_nxt     = '0;
         odd_ovf_nxt  = 1'b0;
         even_ovf_nxt = 1'b0;
      end else begin
         if (inc_odd) begin
            if (odd_at_max) begin
               odd_nxt     = SAT_MODE ? CNT_MAX : '0;
               odd_ovf_nxt = 1'b1;
            end else begin
               odd_nxt = count_odd + CNT_W'(1);
            end
         end
         if (inc_even) begin
            if (even_at_max) begin
               even_nxt     = SAT_MODE ? CNT_MAX : '0;
               even_ovf_nxt = 1'b1;
            end else begin
               even_nxt = count_even + CNT_W'(1);
            end
         end
      end
   end

   // Count and overflow registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_odd  <= '0;
         count_even <= '0;
         odd_ovf    <= 1'b0;
         even_ovf   <= 1'b0;
      end else begin
         count_odd  <= odd_nxt;
         count_even <= even_nxt;
         odd_ovf    <= odd_ovf_nxt;
         even_ovf   <= even_ovf_nxt;
      end
   end

   // Majority flags compare the registered counts, so they trail counts by one edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         odd_major  <= 1'b0;
         even_major <= 1'b0;
      end else if (clr) begin
         odd_major  <= 1'b0;
         even_major <= 1'b0;
      end else begin
         odd_major  <= (count_odd > count_even);
         even_major <= (count_even > count_odd);
      end
   end

   // Total is one bit wider than each counter so it can never overflow.
   assign count_total = TOT_W'(count_odd) + TOT_W'(count_even);

endmodule

// File: tb/tb_parity_stream_counter.sv
// Directed self-checking bench: wrap and saturate instances share one stimulus stream.
module tb_parity_stream_counter;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              in_valid;
   logic [DATA_W-1:0] d_in;

   logic [CNT_W-1:0]  w_odd, w_even, s_odd, s_even;
   logic [CNT_W:0]    w_total, s_total;
   logic              w_oovf, w_eovf, w_omaj, w_emaj;
   logic              s_oovf, s_eovf, s_omaj, s_emaj;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   parity_stream_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SAT_MODE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .d_in(d_in),
      .count_odd(w_odd), .count_even(w_even), .count_total(w_total),
      .odd_ovf(w_oovf), .even_ovf(w_eovf), .odd_major(w_omaj), .even_major(w_emaj)
   );

   parity_stream_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SAT_MODE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .d_in(d_in),
      .count_odd(s_odd), .count_even(s_even), .count_total(s_total),
      .odd_ovf(s_oovf), .even_ovf(s_eovf), .odd_major(s_omaj), .even_major(s_emaj)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one edge worth of inputs at the falling edge, return just after the rising edge.
   task automatic step(input logic c, input logic v, input logic [DATA_W-1:0] d);
      @(negedge clk);
      clr      = c;
      in_valid = v;
      d_in     = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      clr      = 1'b0;
      in_valid = 1'b0;
      d_in     = '0;
      #2;
      check_eq("rst_odd",   32'(w_odd), 0);
      check_eq("rst_even",  32'(w_even), 0);
      check_eq("rst_total", 32'(w_total), 0);
      check_eq("rst_flags", 32'({w_oovf, w_eovf, w_omaj, w_emaj}), 0);
      @(negedge clk);
      rst = 1'b1;

      // Basic classification: 3 odd, 2 even.
      step(1'b0, 1'b1, 4'b0011);
      check_eq("first_odd", 32'(w_odd), 1);
      step(1'b0, 1'b1, 4'b1010);
      step(1'b0, 1'b1, 4'b1011);
      step(1'b0, 1'b1, 4'b1010);
      step(1'b0, 1'b1, 4'b1011);
      check_eq("t1_odd",   32'(w_odd), 3);
      check_eq("t1_even",  32'(w_even), 2);
      check_eq("t1_total", 32'(w_total), 5);
      check_eq("t1_omaj_lag", 32'(w_omaj), 0);

      // Idle with odd-looking data: counts hold, majority catches up.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'b1111);
      check_eq("idle_odd",  32'(w_odd), 3);
      check_eq("idle_even", 32'(w_even), 2);
      check_eq("t1_omaj",   32'(w_omaj), 1);
      check_eq("t1_emaj",   32'(w_emaj), 0);

      step(1'b0, 1'b1, 4'b0000);
      check_eq("zero_odd",  32'(w_odd), 3);
      check_eq("zero_even", 32'(w_even), 3);

      // Clear wins over a concurrent valid word.
      step(1'b1, 1'b1, 4'b0001);
      check_eq("clr_odd",   32'(w_odd), 0);
      check_eq("clr_even",  32'(w_even), 0);
      check_eq("clr_flags", 32'({w_oovf, w_eovf, w_omaj, w_emaj}), 0);
      step(1'b0, 1'b1, 4'b0001);
      check_eq("post_clr_odd", 32'(w_odd), 1);

      // Overflow: 20 odd words into both wrap and saturate instances.
      step(1'b1, 1'b0, 4'b0000);
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b1, 4'b0101);
         check_eq($sformatf("wrap_odd_%0d", i), 32'(w_odd), 32'(i % 16));
         check_eq($sformatf("wrap_ovf_%0d", i), 32'(w_oovf), (i >= 16) ? 1 : 0);
         check_eq($sformatf("sat_odd_%0d", i),  32'(s_odd), (i >= 15) ? 15 : 32'(i));
         check_eq($sformatf("sat_ovf_%0d", i),  32'(s_oovf), (i >= 16) ? 1 : 0);
      end
      check_eq("wrap_eovf", 32'(w_eovf), 0);
      check_eq("sat_eovf",  32'(s_eovf), 0);
      check_eq("sat_total", 32'(s_total), 15);
      step(1'b0, 1'b0, 4'b0000);
      check_eq("wrap_omaj", 32'(w_omaj), 1);
      check_eq("sat_omaj",  32'(s_omaj), 1);

      // Build count_even=7, then reset asynchronously while the clock is low.
      step(1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'b0110);
      check_eq("pre_rst_even", 32'(w_even), 7);
      @(negedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("arst_even",  32'(w_even), 0);
      check_eq("arst_total", 32'(w_total), 0);
      check_eq("arst_flags", 32'({w_oovf, w_eovf, w_omaj, w_emaj}), 0);
      check_eq("arst_sat",   32'(s_even), 0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b1, 4'b1000);
      step(1'b0, 1'b1, 4'b1000);
      check_eq("rel_even", 32'(w_even), 2);
      check_eq("rel_odd",  32'(w_odd), 0);
      step(1'b0, 1'b0, 4'b0000);
      check_eq("rel_emaj", 32'(w_emaj), 1);
      check_eq("rel_omaj", 32'(w_omaj), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
